// File: rtl/end_text_ctrl.sv
// end_text_ctrl: clears a 16x16 character buffer and writes "PLAYER n WINS" for the end-of-game overlay.
// Optional blinking of the overlay in SHOW is enabled by defining END_TEXT_BLINK_EN.
module end_text_ctrl #(
   parameter logic [3:0] MSG_ROW      = 4'd7,
   parameter logic [3:0] MSG_COL      = 4'd1,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_over_i,
   input  logic [1:0] winner_i,
   input  logic       restart_i,
   input  logic       vsync_i,
   input  logic [7:0] char_xy_i,
   output logic [6:0] char_code_o,
   output logic       overlay_en_o,
   output logic       busy_o,
   output logic       done_o
);
   typedef enum logic [1:0] {IDLE, CLEAR, WRITE, SHOW} state_t;
   localparam logic [103:0] MSG = "PLAYER n WINS";
   if (int'(MSG_COL) + 13 > 16) begin : g_col_chk
      $error("end_text_ctrl: message does not fit in the buffer row");
   end
   state_t      state_q, state_d;
   logic [7:0]  ptr_q, ptr_d;
   logic [3:0]  i_q, i_d;
   logic [1:0]  win_q, win_d;
   logic        go_q, go_rise;
   logic        done_q, done_d;
   logic        we;
   logic [7:0]  wa;
   logic [6:0]  wd, msg_ch;
   logic [6:0]  code_q;
   logic [6:0]  ram_q [256];
   assign go_rise = game_over_i & ~go_q;
   always_comb begin
      msg_ch = (i_q == 4'd7) ? 7'h30 + {5'd0, win_q} : MSG[8*(12-i_q) +: 7];
      state_d = state_q;
      ptr_d   = ptr_q;
      i_d     = i_q;
      win_d   = win_q;
      done_d  = 1'b0;
      we      = 1'b0;
      wa      = ptr_q;
      wd      = 7'h20;
      case (state_q)
         IDLE: if (go_rise) begin
            state_d = CLEAR;
            win_d   = winner_i;
            ptr_d   = '0;
         end
         CLEAR: begin
            we = 1'b1;
            if (ptr_q == 8'hFF) begin
               state_d = WRITE;
               i_d     = '0;
            end else
               ptr_d = ptr_q + 8'd1;
         end
         WRITE: begin
            we = 1'b1;
            wa = {MSG_ROW, 4'(MSG_COL + i_q)};
            wd = msg_ch;
            if (i_q == 4'd12) begin
               state_d = SHOW;
               done_d  = 1'b1;
            end else
               i_d = i_q + 4'd1;
         end
         default: ;
      endcase
      // restart beats everything, including a same-cycle game_over rise in IDLE
      if (restart_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         i_q     <= '0;
         win_q   <= '0;
         go_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         i_q     <= i_d;
         win_q   <= win_d;
         go_q    <= game_over_i;
         done_q  <= done_d;
      end
   end
   always_ff @(posedge clk) begin
      if (we) ram_q[wa] <= wd;
   end
   always_ff @(posedge clk) begin
      if (rst) code_q <= '0;
      else code_q <= ram_q[char_xy_i];
   end
   assign char_code_o = code_q;
   assign busy_o      = (state_q == CLEAR) || (state_q == WRITE);
   assign done_o      = done_q;
`ifdef END_TEXT_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   logic          vs_q, blink_q, wrap;
   logic [FW-1:0] fc_q;
   assign wrap = (fc_q == FW'(BLINK_FRAMES - 1));
   // vs_q resets high so the first cycle out of reset cannot look like an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q    <= 1'b1;
         fc_q    <= '0;
         blink_q <= 1'b1;
      end else begin
         vs_q <= vsync_i;
         if (state_d == SHOW && state_q != SHOW) begin
            fc_q    <= '0;
            blink_q <= 1'b1;
         end else if (state_q == SHOW && vsync_i && !vs_q) begin
            fc_q    <= wrap ? '0 : fc_q + 1'b1;
            blink_q <= wrap ? ~blink_q : blink_q;
         end
      end
   end
   assign overlay_en_o = (state_q == SHOW) && blink_q;
`else
   logic unused_cfg;
   assign unused_cfg   = vsync_i | (BLINK_FRAMES == 0);
   assign overlay_en_o = (state_q == SHOW);
`endif
endmodule

// File: tb/tb_end_text_ctrl.sv
// tb_end_text_ctrl: directed checks of the end-text sequencer, buffer contents and restart handling.
module tb_end_text_ctrl;
   logic       clk = 1'b0, rst = 1'b1;
   logic       game_over_i = 1'b0, restart_i = 1'b0, vsync_i = 1'b0;
   logic [1:0] winner_i = '0;
   logic [7:0] char_xy_i = '0;
   logic [6:0] char_code_o;
   logic       overlay_en_o, busy_o, done_o;
   int         errs = 0, checks = 0;
   always #5 clk = ~clk;
   end_text_ctrl #(.BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .game_over_i(game_over_i), .winner_i(winner_i),
      .restart_i(restart_i), .vsync_i(vsync_i), .char_xy_i(char_xy_i),
      .char_code_o(char_code_o), .overlay_en_o(overlay_en_o), .busy_o(busy_o), .done_o(done_o)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // rise game_over and follow the whole sequence; rbw checks the read-before-write on 8'h78
   task automatic run_seq(input logic [1:0] w, input bit rbw);
      int cnt;
      cnt = 0;
      winner_i = w;
      game_over_i = 1'b1;
      tick();
      while (busy_o && cnt < 400) begin
         cnt++;
         if (cnt == 5) winner_i = ~w;
         if (cnt == 10) game_over_i = 1'b0;
         if (cnt == 11) game_over_i = 1'b1;
         if (rbw && cnt == 265) chk("rbw_old", char_code_o, 32'h20);
         if (rbw && cnt == 266) chk("rbw_new", char_code_o, 32'h30 + w);
         if (cnt == 269) chk("done_early", done_o, 0);
         tick();
      end
      chk("busy_len", cnt, 269);
      chk("done_pulse", done_o, 1);
      chk("ov_show", overlay_en_o, 1);
      tick();
      chk("done_drop", done_o, 0);
      chk("ov_hold", overlay_en_o, 1);
   endtask
   initial begin
      logic [103:0] m;
      logic [7:0]   e;
      logic [5:0]   pat;
      m = "PLAYER 2 WINS";
      pat = 6'b110011;
      repeat (3) tick();
      chk("rst_ov", overlay_en_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_code", char_code_o, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy_o, 0);
      run_seq(2'd2, 1'b0);
      for (int a = 0; a < 256; a++) begin
         char_xy_i = 8'(a);
         tick();
         e = (a / 16 == 7 && a % 16 >= 1 && a % 16 <= 13) ? m[8*(13 - a % 16) +: 8] : 8'h20;
         chk($sformatf("rd_%02h", a), char_code_o, e);
      end
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk("rs_show_ov", overlay_en_o, 0);
      chk("rs_show_busy", busy_o, 0);
      game_over_i = 1'b0;
      tick();
      winner_i = 2'd1;
      game_over_i = 1'b1;
      tick();
      chk("abort_busy", busy_o, 1);
      repeat (99) tick();
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk("abort_idle", busy_o, 0);
      chk("abort_done", done_o, 0);
      chk("abort_ov", overlay_en_o, 0);
      repeat (3) tick();
      chk("abort_stay", busy_o, 0);
      game_over_i = 1'b0;
      char_xy_i = 8'h78;
      tick();
      run_seq(2'd2, 1'b1);
      for (int k = 0; k < 6; k++) begin
`ifdef END_TEXT_BLINK_EN
         chk($sformatf("blink_%0d", k), overlay_en_o, pat[5-k]);
`else
         chk($sformatf("blink_%0d", k), overlay_en_o, 1);
`endif
         vsync_i = 1'b1;
         tick();
         vsync_i = 1'b0;
         repeat (2) tick();
      end
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      game_over_i = 1'b0;
      tick();
      game_over_i = 1'b1;
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk("tie_busy", busy_o, 0);
      tick();
      chk("tie_consumed", busy_o, 0);
      tick();
      chk("tie_ov", overlay_en_o, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
